// File: rtl/mips_regfile_sb.sv
// mips_regfile_sb: MIPS-style register file with two write ports, optional
// write-to-read forwarding, and a per-register busy scoreboard.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   addrA/addrB -> BusA/BusB   combinational read ports
//   wEn/addrW/BusW        write port 0 (ALU writeback)
//   wEn2/addrW2/BusW2     write port 1 (load return, wins on same address)
//   issEn/issAddr         marks issue of an instruction that will write issAddr
//   busyA/busyB           combinational pending-write flags for addrA/addrB
//   pendCnt               registered count of busy registers
//   wrConflict            registered one-cycle same-address dual-write pulse
module mips_regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   addrA,
  input  logic [ADDR_W-1:0]   addrB,
  output logic [DATA_W-1:0]   BusA,
  output logic [DATA_W-1:0]   BusB,
  input  logic                wEn,
  input  logic [ADDR_W-1:0]   addrW,
  input  logic [DATA_W-1:0]   BusW,
  input  logic                wEn2,
  input  logic [ADDR_W-1:0]   addrW2,
  input  logic [DATA_W-1:0]   BusW2,
  input  logic                issEn,
  input  logic [ADDR_W-1:0]   issAddr,
  output logic                busyA,
  output logic                busyB,
  output logic [ADDR_W:0]     pendCnt,
  output logic                wrConflict
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic [CNT_W-1:0]  cnt_next;
  logic              w0_act;
  logic              w1_act;
  logic              hit_a;
  logic              hit_b;
  logic              conflict_c;

  // Writes to r0 are architecturally dropped, so they never count as active.
  assign w0_act     = wEn  && (addrW  != '0);
  assign w1_act     = wEn2 && (addrW2 != '0);
  assign conflict_c = w0_act && w1_act && (addrW == addrW2);

  assign hit_a = (w0_act && (addrW == addrA)) || (w1_act && (addrW2 == addrA));
  assign hit_b = (w0_act && (addrW == addrB)) || (w1_act && (addrW2 == addrB));

  // Register array; port 1 assignment comes last so it wins on a shared address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (w0_act) regs[addrW]  <= BusW;
      if (w1_act) regs[addrW2] <= BusW2;
    end
  end

  // Read ports with optional forwarding; reset forces zero even on a live write.
  always_comb begin
    BusA = regs[addrA];
    BusB = regs[addrB];
    if (BYPASS != 0) begin
      if (w0_act && (addrW == addrA))  BusA = BusW;
      if (w1_act && (addrW2 == addrA)) BusA = BusW2;
      if (w0_act && (addrW == addrB))  BusB = BusW;
      if (w1_act && (addrW2 == addrB)) BusB = BusW2;
    end
    if (!rst_n) begin
      BusA = '0;
      BusB = '0;
    end
  end

  // A forwarded read already carries the producer's data, so it is not busy.
  always_comb begin
    busyA = busy[addrA];
    busyB = busy[addrB];
    if (BYPASS != 0) begin
      if (hit_a) busyA = 1'b0;
      if (hit_b) busyB = 1'b0;
    end
  end

  // Scoreboard next state: writes clear, a same-cycle issue re-sets (new producer).
  always_comb begin
    busy_next = busy;
    if (w0_act) busy_next[addrW]  = 1'b0;
    if (w1_act) busy_next[addrW2] = 1'b0;
    if (issEn && (issAddr != '0)) busy_next[issAddr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Population count of the next busy vector.
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      cnt_next = cnt_next + CNT_W'(busy_next[i]);
    end
  end

  // Scoreboard, pending count and conflict pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      pendCnt    <= '0;
      wrConflict <= 1'b0;
    end else begin
      busy       <= busy_next;
      pendCnt    <= cnt_next;
      wrConflict <= conflict_c;
    end
  end

endmodule

// File: tb/tb_mips_regfile_sb.sv
// tb_mips_regfile_sb: scoreboard bench for mips_regfile_sb. Two instances share
// all inputs, one with forwarding and one without; a reference model pushes the
// expected outputs to a queue at drive time, popped at the falling edge.
module tb_mips_regfile_sb;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addrA, addrB, addrW, addrW2, issAddr;
  logic [DW-1:0] BusW, BusW2;
  logic          wEn, wEn2, issEn;

  logic [DW-1:0] bus_a1, bus_b1, bus_a0, bus_b0;
  logic          busy_a1, busy_b1, busy_a0, busy_b0;
  logic [AW:0]   pend1, pend0;
  logic          conf1, conf0;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_q [$];

  logic [DW-1:0] m_regs [NREG];
  logic          m_busy [NREG];
  int            m_cnt;
  logic          m_conf;

  always #5 clk = ~clk;

  mips_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .addrA(addrA), .addrB(addrB),
    .BusA(bus_a1), .BusB(bus_b1),
    .wEn(wEn), .addrW(addrW), .BusW(BusW),
    .wEn2(wEn2), .addrW2(addrW2), .BusW2(BusW2),
    .issEn(issEn), .issAddr(issAddr),
    .busyA(busy_a1), .busyB(busy_b1), .pendCnt(pend1), .wrConflict(conf1)
  );

  mips_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .addrA(addrA), .addrB(addrB),
    .BusA(bus_a0), .BusB(bus_b0),
    .wEn(wEn), .addrW(addrW), .BusW(BusW),
    .wEn2(wEn2), .addrW2(addrW2), .BusW2(BusW2),
    .issEn(issEn), .issAddr(issAddr),
    .busyA(busy_a0), .busyB(busy_b0), .pendCnt(pend0), .wrConflict(conf0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_next(input string tag, input logic [31:0] got);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got %h, scoreboard queue empty", tag, got);
    end else begin
      e = exp_q.pop_front();
      check(tag, got, e);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NREG); i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_cnt  = 0;
    m_conf = 1'b0;
  endtask

  // Reference model update at a rising edge, using the current inputs.
  task automatic model_edge();
    m_conf = wEn && wEn2 && (addrW == addrW2) && (addrW != 0);
    if (wEn  && addrW  != 0) begin m_regs[addrW]  = BusW;  m_busy[addrW]  = 1'b0; end
    if (wEn2 && addrW2 != 0) begin m_regs[addrW2] = BusW2; m_busy[addrW2] = 1'b0; end
    if (issEn && issAddr != 0) m_busy[issAddr] = 1'b1;
    m_cnt = 0;
    for (int i = 0; i < int'(NREG); i++) if (m_busy[i]) m_cnt++;
  endtask

  function automatic logic [31:0] exp_read(input bit byp, input logic [AW-1:0] a);
    logic [31:0] v;
    v = m_regs[a];
    if (byp && a != 0) begin
      if (wEn2 && addrW2 == a)     v = BusW2;
      else if (wEn && addrW == a)  v = BusW;
    end
    return v;
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [AW-1:0] a);
    logic hit;
    hit = (a != 0) && ((wEn && addrW == a) || (wEn2 && addrW2 == a));
    return m_busy[a] && !(byp && hit);
  endfunction

  task automatic push_all();
    exp_q.push_back(exp_read(1'b1, addrA));
    exp_q.push_back(exp_read(1'b1, addrB));
    exp_q.push_back(exp_read(1'b0, addrA));
    exp_q.push_back(exp_read(1'b0, addrB));
    exp_q.push_back(32'(exp_busy(1'b1, addrA)));
    exp_q.push_back(32'(exp_busy(1'b1, addrB)));
    exp_q.push_back(32'(exp_busy(1'b0, addrA)));
    exp_q.push_back(32'(exp_busy(1'b0, addrB)));
    exp_q.push_back(32'(m_cnt));
    exp_q.push_back(32'(m_cnt));
    exp_q.push_back(32'(m_conf));
    exp_q.push_back(32'(m_conf));
  endtask

  task automatic pop_all();
    check_next("bus_a_byp",  bus_a1);
    check_next("bus_b_byp",  bus_b1);
    check_next("bus_a_nobyp", bus_a0);
    check_next("bus_b_nobyp", bus_b0);
    check_next("busy_a_byp", 32'(busy_a1));
    check_next("busy_b_byp", 32'(busy_b1));
    check_next("busy_a_nobyp", 32'(busy_a0));
    check_next("busy_b_nobyp", 32'(busy_b0));
    check_next("pend_cnt_byp", 32'(pend1));
    check_next("pend_cnt_nobyp", 32'(pend0));
    check_next("wr_conflict_byp", 32'(conf1));
    check_next("wr_conflict_nobyp", 32'(conf0));
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] aw, input logic [DW-1:0] dw,
                       input logic we2, input logic [AW-1:0] aw2, input logic [DW-1:0] dw2,
                       input logic ie, input logic [AW-1:0] ia,
                       input logic [AW-1:0] aa, input logic [AW-1:0] ab);
    wEn = we;  addrW = aw;  BusW = dw;
    wEn2 = we2; addrW2 = aw2; BusW2 = dw2;
    issEn = ie; issAddr = ia;
    addrA = aa; addrB = ab;
  endtask

  // One clock of stimulus: drive, predict, sample at falling edge, advance model.
  task automatic cycle(input logic we, input logic [AW-1:0] aw, input logic [DW-1:0] dw,
                       input logic we2, input logic [AW-1:0] aw2, input logic [DW-1:0] dw2,
                       input logic ie, input logic [AW-1:0] ia,
                       input logic [AW-1:0] aa, input logic [AW-1:0] ab);
    drive(we, aw, dw, we2, aw2, dw2, ie, ia, aa, ab);
    push_all();
    @(negedge clk);
    pop_all();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic check_reset_zero();
    for (int i = 0; i < 12; i++) exp_q.push_back(32'h0);
    pop_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          r_we, r_we2, r_ie;
    logic [AW-1:0] r_aw, r_aw2, r_ia, r_aa, r_ab;
    logic [DW-1:0] r_dw, r_dw2;

    model_reset();
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 32'h1111_2222, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd0);
    #3;
    check_reset_zero();
    @(posedge clk);
    #2;
    check_reset_zero();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    rst_n = 1'b1;

    // Basic write/read and r0 protection
    cycle(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd0);
    cycle(0, 5'd0, 32'h0,         0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd5);
    cycle(1, 5'd0, 32'h0000_1234, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd5);
    cycle(0, 5'd0, 32'h0,         0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd5);
    // Same-cycle forwarding versus stored-only read
    cycle(1, 5'd7, 32'h11,        0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd7);
    cycle(0, 5'd0, 32'h0,         0, 5'd0, 32'h0, 0, 5'd0, 5'd7, 5'd7);
    // Dual write same address: port 1 wins, one-cycle conflict pulse
    cycle(1, 5'd3, 32'hAAAA,      1, 5'd3, 32'h5555, 0, 5'd0, 5'd3, 5'd7);
    cycle(0, 5'd0, 32'h0,         0, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd3);
    cycle(0, 5'd0, 32'h0,         0, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd0);
    // Dual write different addresses both commit
    cycle(1, 5'd12, 32'hC0C0,     1, 5'd13, 32'hD0D0, 0, 5'd0, 5'd12, 5'd13);
    cycle(0, 5'd0, 32'h0,         0, 5'd0, 32'h0, 0, 5'd0, 5'd12, 5'd13);
    // Scoreboard: issue r8, r9, r8 again
    cycle(0, 5'd0, 32'h0,         0, 5'd0, 32'h0, 1, 5'd8, 5'd8, 5'd9);
    cycle(0, 5'd0, 32'h0,         0, 5'd0, 32'h0, 1, 5'd9, 5'd8, 5'd9);
    cycle(0, 5'd0, 32'h0,         0, 5'd0, 32'h0, 1, 5'd8, 5'd8, 5'd9);
    cycle(0, 5'd0, 32'h0,         0, 5'd0, 32'h0, 0, 5'd0, 5'd8, 5'd9);
    cycle(1, 5'd8, 32'h88,        0, 5'd0, 32'h0, 0, 5'd0, 5'd8, 5'd9);
    cycle(0, 5'd0, 32'h0,         0, 5'd0, 32'h0, 0, 5'd0, 5'd8, 5'd9);
    // Issue and write r9 in the same cycle: new producer keeps it busy
    cycle(0, 5'd0, 32'h0,         1, 5'd9, 32'h99, 1, 5'd9, 5'd9, 5'd8);
    cycle(0, 5'd0, 32'h0,         0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd8);
    // r0 is never busy and never written
    cycle(1, 5'd0, 32'hFFFF,      1, 5'd0, 32'hEEEE, 1, 5'd0, 5'd0, 5'd9);
    cycle(0, 5'd0, 32'h0,         0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);

    // Randomised traffic over a small address window to provoke collisions
    repeat (200) begin
      r_we  = 1'($urandom_range(0, 1));
      r_we2 = 1'($urandom_range(0, 1));
      r_ie  = 1'($urandom_range(0, 1));
      r_aw  = AW'($urandom_range(0, 7));
      r_aw2 = AW'($urandom_range(0, 7));
      r_ia  = AW'($urandom_range(0, 7));
      r_aa  = AW'($urandom_range(0, 7));
      r_ab  = AW'($urandom_range(0, 7));
      r_dw  = $urandom;
      r_dw2 = $urandom;
      cycle(r_we, r_aw, r_dw, r_we2, r_aw2, r_dw2, r_ie, r_ia, r_aa, r_ab);
    end

    // Mid-operation reset discards data and scoreboard immediately
    cycle(1, 5'd4, 32'h77,        0, 5'd0, 32'h0, 1, 5'd6, 5'd4, 5'd6);
    cycle(0, 5'd0, 32'h0,         0, 5'd0, 32'h0, 0, 5'd0, 5'd4, 5'd6);
    drive(1'b1, 5'd4, 32'hFFFF, 1'b1, 5'd6, 32'hABCD, 1'b1, 5'd6, 5'd4, 5'd6);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_zero();
    @(posedge clk);
    #2;
    check_reset_zero();
    model_reset();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd6);
    rst_n = 1'b1;
    cycle(0, 5'd0, 32'h0,         0, 5'd0, 32'h0, 0, 5'd0, 5'd4, 5'd6);
    cycle(1, 5'd4, 32'h55,        0, 5'd0, 32'h0, 1, 5'd6, 5'd4, 5'd6);
    cycle(0, 5'd0, 32'h0,         0, 5'd0, 32'h0, 0, 5'd0, 5'd4, 5'd6);

    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_regfile_sb.md
MIPS_REGFILE_SB -- requirements
Module: mips_regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register and bus width.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; depth = 2**ADDR_W registers.
REQ-003 Parameter BYPASS, default 1, SHALL enable (1) or disable (0) write-to-read forwarding.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 addrA, addrB  in  ADDR_W  SHALL be the read addresses.
REQ-007 BusA, BusB  out  DATA_W  SHALL be the combinational read data.
REQ-008 wEn, addrW, BusW  in  1/ADDR_W/DATA_W  SHALL be write port 0 (ALU writeback).
REQ-009 wEn2, addrW2, BusW2  in  1/ADDR_W/DATA_W  SHALL be write port 1 (load return).
REQ-010 issEn, issAddr  in  1/ADDR_W  SHALL mark the issue of an instruction that will write issAddr.
REQ-011 busyA, busyB  out  1  SHALL flag a pending write to addrA / addrB.
REQ-012 pendCnt  out  ADDR_W+1  SHALL be the registered count of busy registers.
REQ-013 wrConflict  out  1  SHALL be a registered one-cycle pulse flagging a same-address dual write.

Function
REQ-014 Register 0 SHALL always read 0, SHALL ignore writes on both ports and SHALL never be busy.
REQ-015 A write with wEn (wEn2) high and nonzero address SHALL update the register at the next rising edge.
REQ-016 Both ports writing the same nonzero address in one cycle: port 1 SHALL win; wrConflict SHALL be 1 for the following cycle only.
REQ-017 Different addresses on both ports in one cycle SHALL both commit.
REQ-018 BYPASS=1: a read whose address matches an active nonzero write this cycle SHALL return that write data (port 1 over port 0); otherwise the stored value.
REQ-019 BYPASS=0: reads SHALL return only stored values; written data SHALL be visible the cycle after the edge.
REQ-020 issEn with nonzero issAddr SHALL set busy[issAddr] at the next edge.
REQ-021 An active nonzero write on either port SHALL clear busy of its address at the next edge.
REQ-022 Issue and write to the same address in one cycle: busy SHALL end 1 (new producer wins).
REQ-023 busyA SHALL equal busy[addrA], forced 0 when BYPASS=1 and a write to addrA is active this cycle; busyB likewise.
REQ-024 pendCnt SHALL equal the number of set busy bits, updated on the same edge as busy; range 0..2**ADDR_W-1, no wrap possible.
REQ-025 Issue to an already-busy register SHALL leave busy 1 and pendCnt unchanged.
REQ-026 A write to a non-busy register SHALL commit data and leave pendCnt unchanged.

Reset
REQ-027 rst_n low SHALL immediately clear all registers to 0, all busy bits, pendCnt and wrConflict, independent of clk.
REQ-028 While rst_n is low, writes and issues SHALL be ignored; BusA/BusB SHALL read 0.
REQ-029 After rst_n rises, the first rising edge SHALL process inputs normally; reset asserted mid-operation SHALL discard all pending state.

Verification
REQ-030 Write r5=0xDEADBEEF on port 0, read addrA=5 next cycle -> BusA=0xDEADBEEF; write r0=0x1234 -> BusA(addr 0)=0.
REQ-031 BYPASS=1, port 0 writes r7=0x11 while addrB=7 -> BusB=0x11 in the same cycle; BYPASS=0 -> old value until after the edge.
REQ-032 Same cycle port 0 r3=0xAAAA, port 1 r3=0x5555 -> r3=0x5555, wrConflict=1 for exactly one cycle.
REQ-033 Issue r8, r9, r8 -> pendCnt=2, busyA(8)=1; write r8 -> busy[8]=0, pendCnt=1; issue r9 + write r9 same cycle -> busy[9]=1, pendCnt=1.
REQ-034 Write r4=0x77, issue r6, then pulse rst_n low between edges -> r4=0, busy all 0, pendCnt=0 immediately.
REQ-035 Issue r0 and write r0 -> pendCnt stays 0, busyA(0)=0, BusA(0)=0.
